axil_ram_slave: RTL and testbench
=================================

# axil_ram_slave

Parametrised AXI4-Lite single-port RAM slave with full read, write and write-response channels, byte strobes, configurable read latency and out-of-range error signalling. It replaces the fixed 32-word, read-mostly fetch and data RAMs in the core test harness and serves as instruction or data memory behind the core's AXI-Lite ports. A non-AXI backdoor load port preloads programs and data from the testbench.

## Interface
- DATA_W, 32: data width in bits; multiple of 8.
- ADDR_W, 32: AXI byte-address width.
- DEPTH, 32: memory depth in DATA_W words; power of two, ≥ 2.
- RD_LAT, 0: extra wait cycles between AR handshake and RVALID; range 0..7.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_en  in  1  backdoor write enable.
- load_addr  in  $clog2(DEPTH)  backdoor word index.
- load_data  in  DATA_W  backdoor write data.
- ARADDR  in  ADDR_W  read byte address.
- ARVALID  in  1  / ARREADY  out  1  read-address handshake.
- RDATA  out  DATA_W  / RRESP  out  2  / RVALID  out  1  / RREADY  in  1  read-data channel.
- AWADDR  in  ADDR_W  write byte address.
- AWVALID  in  1  / AWREADY  out  1  write-address handshake.
- WDATA  in  DATA_W  / WSTRB  in  DATA_W/8  / WVALID  in  1  / WREADY  out  1  write-data channel.
- BRESP  out  2  / BVALID  out  1  / BREADY  in  1  write-response channel.

## Operation
- Word index = ADDR >> log2(DATA_W/8).
- Address is in range iff index < DEPTH. Out of range:
  - Read: RDATA = 0, RRESP = 2'b10 (SLVERR).
  - Write: dropped, BRESP = 2'b10.
  - Otherwise RESP = 2'b00 (OKAY).
- Memory array is not reset; contents survive rst.
- Read FSM:
  - R_IDLE: ARREADY = 1. On ARVALID, capture address. Go to R_WAIT if RD_LAT > 0, else R_RESP.
  - R_WAIT: 3-bit counter counts RD_LAT cycles, then R_RESP.
  - R_RESP: RVALID = 1; RDATA and RRESP held stable. On RREADY, go to R_IDLE.
- Write FSM:
  - W_IDLE: AWREADY = 1 until AW is captured; WREADY = 1 until W is captured.
  - AW and W are accepted in either order or in the same cycle, each into its own holding register.
  - On the edge where the second of the pair is captured: commit the write (byte lane i written iff WSTRB[i]), set BRESP, go to W_RESP.
  - W_RESP: BVALID = 1; AWREADY = WREADY = 0. On BREADY, go to W_IDLE.
- Read and write FSMs are fully independent.
- Read data is sampled from the array on the edge entering R_RESP.
  - A write or load committing on that same edge is not visible; the old data is returned.
- Backdoor load_en writes the full word unconditionally.
  - If it collides with an AXI commit to the same word on the same edge, the load wins.

## Timing
- Reset values: ARREADY = AWREADY = WREADY = 1; RVALID = BVALID = 0; RDATA = 0; RRESP = BRESP = 2'b00.
  - Both FSMs reset to their IDLE states; counters and holding registers reset to 0.
- Read: AR handshake at edge N → RVALID high from edge N+1+RD_LAT.
  - Read throughput: one transfer per 2+RD_LAT cycles when RREADY = 1.
- Write: last of AW/W captured at edge N → memory updated and BVALID high at edge N+1.
  - AWREADY and WREADY return high the cycle after the B handshake.
- RVALID and BVALID never drop without their ready. Payloads do not change while valid is high.
- rst asserted mid-transaction aborts immediately:
  - An uncommitted write is discarded.
  - A pending read is lost.
  - Outputs take their reset values asynchronously.

## Test plan
- Backdoor load 0xDEADBEEF at index 3; AR 0x0C, RD_LAT = 0 → RVALID 1 cycle after AR, RDATA = 0xDEADBEEF, RRESP = 0.
- Write 0x11223344 with WSTRB = 4'b0101 over 0xFFFFFFFF at 0x08, W one cycle before AW → BVALID 1 cycle after AW, BRESP = 0; readback = 0xFF22FF44.
- RD_LAT = 3, RREADY held low 5 cycles → RVALID at N+4, RDATA stable until the RREADY handshake; ARREADY low throughout.
- AR and AW at address DEPTH×4 → RRESP = 2'b10 with RDATA = 0; BRESP = 2'b10; memory unchanged.
- Same-edge AXI write 0xAAAA_AAAA and load_en 0x5555_5555 to index 0 → readback 0x5555_5555.
- Drop rst low while BVALID is pending → BVALID = 0 immediately; after release, AWREADY = WREADY = 1 and preloaded memory contents are intact.

Source files
------------

// File: rtl/axil_ram_slave.sv
// AXI4-Lite single-port RAM slave with byte strobes, configurable read latency,
// SLVERR on out-of-range addresses and a backdoor word-load port.
module axil_ram_slave #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned RD_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic [ADDR_W-1:0]        ARADDR,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [DATA_W-1:0]        RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic [ADDR_W-1:0]        AWADDR,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [DATA_W-1:0]        WDATA,
  input  logic [DATA_W/8-1:0]      WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [2:0]  LAT    = 3'(RD_LAT);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
  typedef enum logic [0:0] {WIdle, WResp} w_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(logic [ADDR_W-1:0] a);
    return (a >> (OFFS_W + IDX_W)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(logic [ADDR_W-1:0] a);
    return a[OFFS_W +: IDX_W];
  endfunction

  // Read channel
  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d, r_sample_addr;
  logic [2:0]        r_cnt_q, r_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              r_sample;

  always_comb begin
    r_state_d     = r_state_q;
    r_addr_d      = r_addr_q;
    r_cnt_d       = r_cnt_q;
    r_sample      = 1'b0;
    r_sample_addr = r_addr_q;
    ARREADY       = 1'b0;
    RVALID        = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        ARREADY = 1'b1;
        if (ARVALID) begin
          r_addr_d = ARADDR;
          r_cnt_d  = '0;
          if (RD_LAT == 0) begin
            r_state_d     = RResp;
            r_sample      = 1'b1;
            r_sample_addr = ARADDR;
          end else begin
            r_state_d = RWait;
          end
        end
      end
      RWait: begin
        if (r_cnt_q == LAT - 3'd1) begin
          r_state_d = RResp;
          r_sample  = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q + 3'd1;
        end
      end
      RResp: begin
        RVALID = 1'b1;
        if (RREADY) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Data is taken on the edge entering RResp, so a same-edge write is not seen.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (r_sample) begin
      if (in_range(r_sample_addr)) begin
        rdata_d = mem[word_idx(r_sample_addr)];
        rresp_d = OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = SLVERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= RIdle;
      r_addr_q  <= '0;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign RDATA = rdata_q;
  assign RRESP = rresp_q;

  // Write channel: AW and W land in separate holding registers in any order
  w_state_e          w_state_q, w_state_d;
  logic              aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              commit;

  always_comb begin
    w_state_d = w_state_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    aw_addr_d = aw_addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        AWREADY = !aw_have_q;
        WREADY  = !w_have_q;
        if (AWVALID && !aw_have_q) begin
          aw_have_d = 1'b1;
          aw_addr_d = AWADDR;
        end
        if (WVALID && !w_have_q) begin
          w_have_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        if (aw_have_d && w_have_d) begin
          commit    = 1'b1;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          bresp_d   = in_range(aw_addr_d) ? OKAY : SLVERR;
          w_state_d = WResp;
        end
      end
      WResp: begin
        BVALID = 1'b1;
        if (BREADY) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= WIdle;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      aw_addr_q <= aw_addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  assign BRESP = bresp_q;

  // Backdoor load is assigned last so it overrides a same-word AXI commit.
  always_ff @(posedge clk) begin
    if (rst && commit && in_range(aw_addr_d)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_d[i]) mem[word_idx(aw_addr_d)][8*i +: 8] <= wdata_d[8*i +: 8];
      end
    end
    if (load_en) mem[load_addr] <= load_data;
  end
endmodule

// File: tb/tb_axil_ram_slave.sv
// Bench for axil_ram_slave: two instances (RD_LAT 0 and 3) checked every cycle against a
// transaction-level model, plus directed literal checks.
module tb_axil_ram_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en [2];
  logic [4:0]  load_addr [2];
  logic [31:0] load_data [2];
  logic [31:0] araddr [2];
  logic        arvalid [2], arready [2];
  logic [31:0] rdata [2];
  logic [1:0]  rresp [2];
  logic        rvalid [2], rready [2];
  logic [31:0] awaddr [2];
  logic        awvalid [2], awready [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        wvalid [2], wready [2];
  logic [1:0]  bresp [2];
  logic        bvalid [2], bready [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axil_ram_slave #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(32), .RD_LAT(g == 0 ? 0 : 3)
    ) u_dut (
      .clk(clk), .rst(rst),
      .load_en(load_en[g]), .load_addr(load_addr[g]), .load_data(load_data[g]),
      .ARADDR(araddr[g]), .ARVALID(arvalid[g]), .ARREADY(arready[g]),
      .RDATA(rdata[g]), .RRESP(rresp[g]), .RVALID(rvalid[g]), .RREADY(rready[g]),
      .AWADDR(awaddr[g]), .AWVALID(awvalid[g]), .AWREADY(awready[g]),
      .WDATA(wdata[g]), .WSTRB(wstrb[g]), .WVALID(wvalid[g]), .WREADY(wready[g]),
      .BRESP(bresp[g]), .BVALID(bvalid[g]), .BREADY(bready[g])
    );
  end

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name, input int d);
    n_cmp++;
    n_bad++;
    $display("FAIL %s dut%0d: timed out waiting for handshake (t=%0t)", name, d, $time);
  endtask

  function automatic int lat_of(input int d);
    return d == 0 ? 0 : 3;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'h80;
  endfunction

  // Transaction-level model: memory image plus pending-transfer bookkeeping.
  logic [31:0] m_mem [2][32];
  bit          m_rbusy [2];
  longint      m_rdue [2];
  logic [31:0] m_raddr [2], m_rdata [2];
  logic [1:0]  m_rresp [2];
  bit          m_aw_have [2], m_w_have [2], m_bpend [2];
  logic [31:0] m_aw_addr [2], m_wdata [2];
  logic [3:0]  m_wstrb [2];
  logic [1:0]  m_bresp [2];
  longint      cyc = 0;
  bit          e_rv, e_bv;
  logic [31:0] tmp;

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_rbusy[d]   = 1'b0;
        m_aw_have[d] = 1'b0;
        m_w_have[d]  = 1'b0;
        m_bpend[d]   = 1'b0;
      end else begin
        e_rv = m_rbusy[d] && (cyc >= m_rdue[d]);
        e_bv = m_bpend[d];
        chk("ARREADY", d, 32'(arready[d]), 32'(!m_rbusy[d]));
        chk("RVALID", d, 32'(rvalid[d]), 32'(e_rv));
        chk("AWREADY", d, 32'(awready[d]), 32'(!m_bpend[d] && !m_aw_have[d]));
        chk("WREADY", d, 32'(wready[d]), 32'(!m_bpend[d] && !m_w_have[d]));
        chk("BVALID", d, 32'(bvalid[d]), 32'(e_bv));
        if (e_rv) begin
          chk("RDATA", d, rdata[d], m_rdata[d]);
          chk("RRESP", d, 32'(rresp[d]), 32'(m_rresp[d]));
        end
        if (e_bv) chk("BRESP", d, 32'(bresp[d]), 32'(m_bresp[d]));
        // Effects of the coming rising edge: reads sample first, then writes, then loads.
        if (e_rv && rready[d]) begin
          m_rbusy[d] = 1'b0;
        end else if (!m_rbusy[d] && arvalid[d]) begin
          m_rbusy[d] = 1'b1;
          m_rdue[d]  = cyc + 1 + lat_of(d);
          m_raddr[d] = araddr[d];
        end
        if (m_rbusy[d] && cyc == m_rdue[d] - 1) begin
          m_rdata[d] = in_rng(m_raddr[d]) ? m_mem[d][m_raddr[d][6:2]] : 32'h0;
          m_rresp[d] = in_rng(m_raddr[d]) ? 2'b00 : 2'b10;
        end
        if (e_bv && bready[d]) begin
          m_bpend[d] = 1'b0;
        end else if (!m_bpend[d]) begin
          if (awvalid[d] && !m_aw_have[d]) begin
            m_aw_have[d] = 1'b1;
            m_aw_addr[d] = awaddr[d];
          end
          if (wvalid[d] && !m_w_have[d]) begin
            m_w_have[d] = 1'b1;
            m_wdata[d]  = wdata[d];
            m_wstrb[d]  = wstrb[d];
          end
          if (m_aw_have[d] && m_w_have[d]) begin
            if (in_rng(m_aw_addr[d])) begin
              tmp = m_mem[d][m_aw_addr[d][6:2]];
              for (int i = 0; i < 4; i++)
                if (m_wstrb[d][i]) tmp[8*i +: 8] = m_wdata[d][8*i +: 8];
              m_mem[d][m_aw_addr[d][6:2]] = tmp;
            end
            m_bresp[d]   = in_rng(m_aw_addr[d]) ? 2'b00 : 2'b10;
            m_bpend[d]   = 1'b1;
            m_aw_have[d] = 1'b0;
            m_w_have[d]  = 1'b0;
          end
        end
        if (load_en[d]) m_mem[d][load_addr[d]] = load_data[d];
      end
    end
    cyc++;
  end

  // All drivers start and end #1 after a rising edge.
  task automatic do_load(input int d, input logic [4:0] idx, input logic [31:0] val);
    load_en[d] = 1'b1;
    load_addr[d] = idx;
    load_data[d] = val;
    @(posedge clk); #1;
    load_en[d] = 1'b0;
  endtask

  task automatic do_read(input int d, input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    bit hs;
    int t;
    int n;
    data = 'x;
    resp = 'x;
    lat = -1;
    araddr[d] = addr;
    arvalid[d] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      hs = arready[d];
      @(posedge clk); #1;
      t++;
    end while (!hs && t < 50);
    arvalid[d] = 1'b0;
    if (!hs) begin
      fail_timeout("AR", d);
      return;
    end
    if (hold == 0) rready[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid[d] && n < 50);
    if (!rvalid[d]) begin
      rready[d] = 1'b0;
      fail_timeout("R", d);
      return;
    end
    lat = n;
    data = rdata[d];
    resp = rresp[d];
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      rready[d] = 1'b1;
    end
    @(posedge clk); #1;
    rready[d] = 1'b0;
  endtask

  // b_hold < 0 leaves the response pending and returns on the negedge BVALID is seen.
  task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_hold, output logic [1:0] resp, output int b_cyc);
    bit aw_done, w_done, aw_hs, w_hs;
    int t;
    int n;
    aw_done = 1'b0;
    w_done = 1'b0;
    resp = 'x;
    b_cyc = -1;
    awaddr[d] = addr;
    wdata[d] = data;
    wstrb[d] = strb;
    t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      if (!aw_done && t >= aw_dly) awvalid[d] = 1'b1;
      if (!w_done && t >= w_dly) wvalid[d] = 1'b1;
      @(negedge clk);
      aw_hs = awvalid[d] && awready[d];
      w_hs = wvalid[d] && wready[d];
      @(posedge clk); #1;
      if (aw_hs) begin awvalid[d] = 1'b0; aw_done = 1'b1; end
      if (w_hs) begin wvalid[d] = 1'b0; w_done = 1'b1; end
      t++;
    end
    if (!(aw_done && w_done)) begin
      awvalid[d] = 1'b0;
      wvalid[d] = 1'b0;
      fail_timeout("AW/W", d);
      return;
    end
    if (b_hold == 0) bready[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bvalid[d] && n < 50);
    if (!bvalid[d]) begin
      bready[d] = 1'b0;
      fail_timeout("B", d);
      return;
    end
    b_cyc = n;
    resp = bresp[d];
    if (b_hold < 0) return;
    if (b_hold > 0) begin
      repeat (b_hold) @(posedge clk);
      #1;
      bready[d] = 1'b1;
    end
    @(posedge clk); #1;
    bready[d] = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 32'h80 | $urandom();
    return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic rand_reads(input int d);
    logic [31:0] dat;
    logic [1:0] rsp;
    int lat;
    repeat (100) begin
      do_read(d, rnd_addr(), $urandom_range(0, 3), dat, rsp, lat);
      chk("rd_latency", d, 32'(lat), 32'(1 + lat_of(d)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  task automatic rand_writes(input int d);
    logic [1:0] rsp;
    int bc;
    repeat (100) begin
      do_write(d, rnd_addr(), $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 2), rsp, bc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  task automatic rand_loads(input int d);
    repeat (40) begin
      repeat ($urandom_range(2, 10)) @(posedge clk);
      #1;
      do_load(d, 5'($urandom_range(0, 31)), $urandom());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic [1:0]  rs, bs;
  int          lt, bc;

  initial begin
    for (int d = 0; d < 2; d++) begin
      load_en[d] = 0; load_addr[d] = 0; load_data[d] = 0;
      araddr[d] = 0; arvalid[d] = 0; rready[d] = 0;
      awaddr[d] = 0; awvalid[d] = 0; wdata[d] = 0; wstrb[d] = 0; wvalid[d] = 0;
      bready[d] = 0;
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ARREADY", d, 32'(arready[d]), 32'h1);
      chk("rst_AWREADY", d, 32'(awready[d]), 32'h1);
      chk("rst_WREADY", d, 32'(wready[d]), 32'h1);
      chk("rst_RVALID", d, 32'(rvalid[d]), 32'h0);
      chk("rst_BVALID", d, 32'(bvalid[d]), 32'h0);
      chk("rst_RDATA", d, rdata[d], 32'h0);
      chk("rst_RRESP", d, 32'(rresp[d]), 32'h0);
      chk("rst_BRESP", d, 32'(bresp[d]), 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      for (int d = 0; d < 2; d++) begin
        load_en[d] = 1'b1;
        load_addr[d] = 5'(i);
        load_data[d] = $urandom();
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) load_en[d] = 1'b0;

    // Backdoor load then zero-latency read
    do_load(0, 5'd3, 32'hDEADBEEF);
    do_read(0, 32'h0C, 0, rd, rs, lt);
    chk("load_read_lat", 0, 32'(lt), 32'd1);
    chk("load_read_data", 0, rd, 32'hDEADBEEF);
    chk("load_read_resp", 0, 32'(rs), 32'h0);

    // Strobed write, W one cycle ahead of AW
    do_load(0, 5'd2, 32'hFFFFFFFF);
    do_write(0, 32'h08, 32'h11223344, 4'b0101, 1, 0, 0, bs, bc);
    chk("strb_b_lat", 0, 32'(bc), 32'd1);
    chk("strb_bresp", 0, 32'(bs), 32'h0);
    do_read(0, 32'h08, 0, rd, rs, lt);
    chk("strb_readback", 0, rd, 32'hFF22FF44);

    // RD_LAT = 3 with RREADY held low for 5 valid cycles
    do_load(1, 5'd7, 32'h0BADF00D);
    do_read(1, 32'h1C, 5, rd, rs, lt);
    chk("lat3_rvalid", 1, 32'(lt), 32'd4);
    chk("lat3_data", 1, rd, 32'h0BADF00D);

    // Out-of-range read and write
    for (int d = 0; d < 2; d++) begin
      do_load(d, 5'd0, 32'h01234567);
      do_read(d, 32'h80, 0, rd, rs, lt);
      chk("oor_rdata", d, rd, 32'h0);
      chk("oor_rresp", d, 32'(rs), 32'h2);
      do_write(d, 32'h80, 32'hFFFFFFFF, 4'hF, 0, 0, 1, bs, bc);
      chk("oor_bresp", d, 32'(bs), 32'h2);
      do_read(d, 32'h00, 0, rd, rs, lt);
      chk("oor_mem_intact", d, rd, 32'h01234567);
    end

    // Same-edge AXI commit and backdoor load to word 0: load wins
    awaddr[0] = 32'h0; wdata[0] = 32'hAAAAAAAA; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1;
    load_en[0] = 1'b1; load_addr[0] = 5'd0; load_data[0] = 32'h55555555;
    @(posedge clk); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; load_en[0] = 1'b0;
    @(posedge clk); #1;
    bready[0] = 1'b0;
    do_read(0, 32'h00, 0, rd, rs, lt);
    chk("collide_readback", 0, rd, 32'h55555555);

    // Reset while BVALID is pending
    do_load(0, 5'd5, 32'hCAFEF00D);
    do_write(0, 32'h24, 32'h12345678, 4'hF, 0, 0, -1, bs, bc);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_BVALID", 0, 32'(bvalid[0]), 32'h0);
    chk("arst_AWREADY", 0, 32'(awready[0]), 32'h1);
    chk("arst_WREADY", 0, 32'(wready[0]), 32'h1);
    chk("arst_RDATA", 0, rdata[0], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    do_read(0, 32'h14, 0, rd, rs, lt);
    chk("arst_mem_intact", 0, rd, 32'hCAFEF00D);
    do_read(0, 32'h24, 0, rd, rs, lt);
    chk("arst_committed", 0, rd, 32'h12345678);

    fork
      rand_reads(0);
      rand_writes(0);
      rand_loads(0);
      rand_reads(1);
      rand_writes(1);
      rand_loads(1);
    join
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
